// File: rtl/axi_ready_shaper.sv
// axi_ready_shaper: per-channel VALID/READY backpressure shaper.
// Sits between an upstream AXI channel (S_*) and a downstream channel (M_*)
// and masks the handshake with a programmable gate. Each channel's gate comes
// from one of four patterns: always open, low/high oscillation, open after
// valid, or LFSR-random. Once VALID has been shown downstream it is held until
// the handshake completes. Each channel also counts its stalled cycles.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   CFG_MODE[2*NCH]     per-channel mode: 0 ALWAYS, 1 OSC, 2 SINGLE, 3 RANDOM
//   CFG_LOW[CNT_W*NCH]  per-channel low time
//   CFG_HIGH[CNT_W*NCH] per-channel high time (OSC) or threshold (RANDOM)
//   CFG_LOAD            pulse: latch CFG_* and restart every channel pattern
//   S_VALID / S_READY   upstream handshake (S_READY = M_READY & gate)
//   M_VALID / M_READY   downstream handshake (M_VALID = S_VALID & gate)
//   GATE[NCH]           effective gate per channel
//   STALL_CNT[16*NCH]   saturating count of S_VALID & ~S_READY cycles
module axi_ready_shaper #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned CNT_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [2*NCH-1:0]     CFG_MODE,
  input  logic [CNT_W*NCH-1:0] CFG_LOW,
  input  logic [CNT_W*NCH-1:0] CFG_HIGH,
  input  logic                 CFG_LOAD,
  input  logic [NCH-1:0]       S_VALID,
  output logic [NCH-1:0]       S_READY,
  output logic [NCH-1:0]       M_VALID,
  input  logic [NCH-1:0]       M_READY,
  output logic [NCH-1:0]       GATE,
  output logic [16*NCH-1:0]    STALL_CNT
);

  localparam int unsigned STALL_W = 16;
  localparam int unsigned LFSR_W  = 16;
  // Bits of the LFSR compared against the random threshold.
  localparam int unsigned RND_W   = (CNT_W < LFSR_W) ? CNT_W : LFSR_W;

  localparam logic [1:0] MODE_ALWAYS = 2'd0;
  localparam logic [1:0] MODE_OSC    = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
  localparam logic [1:0] MODE_RANDOM = 2'd3;

  // One state space covers every mode; the mode itself is implied by the
  // state, so no separate mode register is kept after a load.
  typedef enum logic [2:0] {
    ST_ALWAYS = 3'd0,
    ST_OSC_LO = 3'd1,
    ST_OSC_HI = 3'd2,
    ST_IDLE   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_OPEN   = 3'd5,
    ST_RAND   = 3'd6
  } state_t;

  for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
    localparam logic [15:0] SEED_X = SEED ^ 16'(i);
    localparam logic [15:0] SEED_I = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;

    logic [1:0]         cfg_mode;
    logic [CNT_W-1:0]   cfg_low;
    logic [CNT_W-1:0]   cfg_high;
    logic [CNT_W-1:0]   cfg_high_eff;

    logic [CNT_W-1:0]   low_q;
    logic [CNT_W-1:0]   high_q;
    logic [CNT_W-1:0]   high_eff;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic               gate_q, gate_d;
    logic               locked_q, locked_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic               gate_eff;
    logic               mv;
    logic               sr;
    logic               hs;
    logic               rand_open;
    logic               lfsr_fb;

    assign cfg_mode     = CFG_MODE[2*i +: 2];
    assign cfg_low      = CFG_LOW[CNT_W*i +: CNT_W];
    assign cfg_high     = CFG_HIGH[CNT_W*i +: CNT_W];
    // A zero high time still opens for one cycle.
    assign cfg_high_eff = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
    assign high_eff     = (high_q == '0) ? CNT_W'(1) : high_q;

    // Combinational masking of the handshake.
    assign gate_eff = gate_q | locked_q;
    assign mv       = S_VALID[i] & gate_eff;
    assign sr       = M_READY[i] & gate_eff;
    assign hs       = mv & M_READY[i];

    assign M_VALID[i]                    = mv;
    assign S_READY[i]                    = sr;
    assign GATE[i]                       = gate_eff;
    assign STALL_CNT[STALL_W*i +: STALL_W] = stall_q;

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign rand_open = (CNT_W'(lfsr_q[RND_W-1:0]) < high_q);

    // Once VALID is visible downstream without READY, keep the gate open.
    assign locked_d = mv & ~M_READY[i];
    assign stall_d  = (S_VALID[i] && !sr && (stall_q != 16'hFFFF)) ?
                      stall_q + STALL_W'(1) : stall_q;

    // State register, shadow config and per-channel counters.
    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        state_q  <= ST_ALWAYS;
        cnt_q    <= '0;
        lfsr_q   <= SEED_I;
        gate_q   <= 1'b0;
        locked_q <= 1'b0;
        stall_q  <= '0;
        low_q    <= '0;
        high_q   <= CNT_W'(1);
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        lfsr_q   <= lfsr_d;
        gate_q   <= gate_d;
        locked_q <= locked_d;
        stall_q  <= stall_d;
        if (CFG_LOAD) begin
          low_q  <= cfg_low;
          high_q <= cfg_high;
        end
      end
    end

    // Next-state: a load restarts from the initial state of the new mode.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      if (CFG_LOAD) begin
        lfsr_d = SEED_I;
        case (cfg_mode)
          MODE_OSC: begin
            if (cfg_low == '0) begin
              state_d = ST_OSC_HI;
              cnt_d   = cfg_high_eff;
            end else begin
              state_d = ST_OSC_LO;
              cnt_d   = cfg_low;
            end
          end
          MODE_SINGLE: begin
            state_d = ST_IDLE;
            cnt_d   = cfg_low;
          end
          MODE_RANDOM: state_d = ST_RAND;
          MODE_ALWAYS: state_d = ST_ALWAYS;
          default:     state_d = ST_ALWAYS;
        endcase
      end else begin
        case (state_q)
          ST_OSC_LO: begin
            if (cnt_q <= CNT_W'(1)) begin
              state_d = ST_OSC_HI;
              cnt_d   = high_eff;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          ST_OSC_HI: begin
            if (cnt_q > CNT_W'(1)) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else if (low_q == '0) begin
              cnt_d = high_eff;
            end else begin
              state_d = ST_OSC_LO;
              cnt_d   = low_q;
            end
          end
          ST_IDLE: begin
            if (S_VALID[i]) begin
              state_d = (low_q == '0) ? ST_OPEN : ST_WAIT;
              cnt_d   = low_q;
            end
          end
          ST_WAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
              state_d = ST_OPEN;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          ST_OPEN: begin
            if (hs) begin
              state_d = ST_IDLE;
            end
          end
          ST_RAND:   lfsr_d = {lfsr_fb, lfsr_q[LFSR_W-1:1]};
          ST_ALWAYS: state_d = ST_ALWAYS;
          default:   state_d = ST_ALWAYS;
        endcase
      end
    end

    // Output decode: registered gate for the state being entered.
    always_comb begin
      gate_d = 1'b0;
      case (state_d)
        ST_ALWAYS, ST_OSC_HI, ST_OPEN: gate_d = 1'b1;
        ST_RAND:                       gate_d = !CFG_LOAD && rand_open;
        default:                       gate_d = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ready_shaper.sv
// Directed bench for axi_ready_shaper (NCH=3, CNT_W=8); channel 0 carries the
// pattern under test, the other channels stay in ALWAYS mode.
module tb_axi_ready_shaper;
  localparam int unsigned NCH   = 3;
  localparam int unsigned CNT_W = 8;

  logic                 ACLK = 1'b0;
  logic                 ARESET;
  logic [2*NCH-1:0]     CFG_MODE;
  logic [CNT_W*NCH-1:0] CFG_LOW;
  logic [CNT_W*NCH-1:0] CFG_HIGH;
  logic                 CFG_LOAD;
  logic [NCH-1:0]       S_VALID;
  logic [NCH-1:0]       S_READY;
  logic [NCH-1:0]       M_VALID;
  logic [NCH-1:0]       M_READY;
  logic [NCH-1:0]       GATE;
  logic [16*NCH-1:0]    STALL_CNT;

  int          ncmp;
  int          nfail;
  int          nhs;
  logic [15:0] m;
  logic        expg;
  logic        fb;

  axi_ready_shaper #(.NCH(NCH), .CNT_W(CNT_W), .SEED(16'hACE1)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .CFG_MODE  (CFG_MODE),
    .CFG_LOW   (CFG_LOW),
    .CFG_HIGH  (CFG_HIGH),
    .CFG_LOAD  (CFG_LOAD),
    .S_VALID   (S_VALID),
    .S_READY   (S_READY),
    .M_VALID   (M_VALID),
    .M_READY   (M_READY),
    .GATE      (GATE),
    .STALL_CNT (STALL_CNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic clk1();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ch, input logic [1:0] mode,
                         input logic [CNT_W-1:0] lo, input logic [CNT_W-1:0] hi);
    CFG_MODE[2*ch +: 2]         = mode;
    CFG_LOW[CNT_W*ch +: CNT_W]  = lo;
    CFG_HIGH[CNT_W*ch +: CNT_W] = hi;
  endtask

  // One reset edge; returns in the first cycle after release (cycle 0).
  task automatic do_reset();
    ARESET   = 1'b1;
    CFG_LOAD = 1'b0;
    S_VALID  = '0;
    M_READY  = '0;
    for (int c = 0; c < int'(NCH); c++) set_cfg(c, 2'd0, 8'd0, 8'd1);
    clk1();
    ARESET = 1'b0;
  endtask

  // Load edge; returns in cycle 1 after CFG_LOAD.
  task automatic do_load();
    CFG_LOAD = 1'b1;
    clk1();
    CFG_LOAD = 1'b0;
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    ARESET = 1'b1;
    CFG_LOAD = 1'b0;
    CFG_MODE = '0;
    CFG_LOW = '0;
    CFG_HIGH = '0;
    S_VALID = '1;
    M_READY = '1;

    // Reset state with traffic offered on every channel.
    clk1();
    clk1();
    #1;
    chk("rst_mvalid", M_VALID, 3'b000);
    chk("rst_sready", S_READY, 3'b000);
    chk("rst_gate", GATE, 3'b000);
    chk("rst_stall", STALL_CNT, 48'h0);
    ARESET = 1'b0;
    #1;
    chk("rel1_gate", GATE, 3'b000);
    clk1();
    #1;
    chk("rel2_gate", GATE, 3'b111);
    chk("rel2_mvalid", M_VALID, 3'b111);
    chk("rel2_stall0", STALL_CNT[15:0], 16'd1);

    // OSC LOW=5 HIGH=1: handshake every 6th cycle, 5 stalls per period.
    do_reset();
    set_cfg(0, 2'd1, 8'd5, 8'd1);
    do_load();
    S_VALID = 3'b001;
    M_READY = 3'b001;
    for (int k = 1; k <= 18; k++) begin
      #1;
      chk($sformatf("osc_hs_c%0d", k), M_VALID[0] & M_READY[0], (k % 6) == 0);
      chk($sformatf("osc_stall_c%0d", k), STALL_CNT[15:0], (k - 1) - (k - 1) / 6);
      clk1();
    end

    // SINGLE LOW=2: VALID at cycle 3 -> gate at cycle 6, then closes.
    do_reset();
    set_cfg(0, 2'd2, 8'd2, 8'd1);
    M_READY = 3'b001;
    do_load();
    for (int k = 1; k <= 2; k++) begin
      #1;
      chk($sformatf("single_idle_c%0d", k), GATE[0], 1'b0);
      clk1();
    end
    S_VALID[0] = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      #1;
      chk($sformatf("single_wait_c%0d", k), M_VALID[0], 1'b0);
      clk1();
    end
    #1;
    chk("single_open_mv", M_VALID[0], 1'b1);
    chk("single_open_sr", S_READY[0], 1'b1);
    clk1();
    S_VALID[0] = 1'b0;
    #1;
    chk("single_closed_gate", GATE[0], 1'b0);
    chk("single_stall", STALL_CNT[15:0], 16'd3);
    clk1();
    #1;
    chk("single_closed2_gate", GATE[0], 1'b0);

    // Lock: OSC LOW=3 HIGH=1, READY withheld 4 cycles after the gate opens.
    do_reset();
    set_cfg(0, 2'd1, 8'd3, 8'd1);
    do_load();
    S_VALID[0] = 1'b1;
    M_READY[0] = 1'b0;
    nhs = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) M_READY[0] = 1'b1;
      #1;
      chk($sformatf("lock_mv_c%0d", k), M_VALID[0], k >= 4);
      chk($sformatf("lock_gate_c%0d", k), GATE[0], k >= 4);
      nhs += int'(M_VALID[0] & M_READY[0]);
      clk1();
    end
    chk("lock_hs_count", nhs, 1);
    S_VALID[0] = 1'b0;
    #1;
    chk("lock_released_gate", GATE[0], 1'b0);
    chk("lock_stall", STALL_CNT[15:0], 16'd7);

    // RANDOM HIGH=0: never opens over 1000 cycles.
    do_reset();
    set_cfg(0, 2'd3, 8'd0, 8'd0);
    do_load();
    S_VALID[0] = 1'b1;
    M_READY[0] = 1'b1;
    nhs = 0;
    repeat (1000) begin
      #1;
      nhs += int'(M_VALID[0] & M_READY[0]);
      clk1();
    end
    #1;
    chk("rand0_hs_count", nhs, 0);
    chk("rand0_stall", STALL_CNT[15:0], 16'd1000);

    // RANDOM HIGH=255: closed only when the previous LFSR low byte is 0xFF.
    do_reset();
    set_cfg(0, 2'd3, 8'd0, 8'd255);
    do_load();
    S_VALID[0] = 1'b1;
    M_READY[0] = 1'b1;
    m = 16'hACE1;
    expg = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      #1;
      chk($sformatf("rand255_gate_c%0d", k), GATE[0], expg);
      expg = (m[7:0] != 8'hFF);
      fb = m[0] ^ m[2] ^ m[3] ^ m[5];
      m = {fb, m[15:1]};
      clk1();
    end

    // Reset mid-OSC count, with a coincident CFG_LOAD that must lose.
    do_reset();
    set_cfg(0, 2'd1, 8'd5, 8'd1);
    do_load();
    S_VALID = 3'b011;
    M_READY = 3'b011;
    clk1();
    clk1();
    ARESET = 1'b1;
    CFG_LOAD = 1'b1;
    #1;
    chk("midrst_pre_mv1", M_VALID[1], 1'b1);
    clk1();
    ARESET = 1'b0;
    CFG_LOAD = 1'b0;
    #1;
    chk("midrst_mvalid", M_VALID, 3'b000);
    chk("midrst_sready", S_READY, 3'b000);
    chk("midrst_stall0", STALL_CNT[15:0], 16'd0);
    clk1();
    #1;
    chk("midrst_2nd_gate0", GATE[0], 1'b1);
    chk("midrst_2nd_hs0", M_VALID[0] & M_READY[0], 1'b1);
    chk("midrst_2nd_stall0", STALL_CNT[15:0], 16'd1);

    // Stall counter saturation with READY held low.
    do_reset();
    set_cfg(0, 2'd1, 8'd255, 8'd1);
    do_load();
    S_VALID[0] = 1'b1;
    M_READY[0] = 1'b0;
    repeat (65534) clk1();
    #1;
    chk("sat_fffe", STALL_CNT[15:0], 16'hFFFE);
    clk1();
    #1;
    chk("sat_ffff", STALL_CNT[15:0], 16'hFFFF);
    repeat (100) clk1();
    #1;
    chk("sat_hold", STALL_CNT[15:0], 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
